// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sharing arbiter.
//   - XLEN / OP_W       : default operand and opcode widths
//   - ALU_* opcodes     : fixed opcode map (0 and 10..15 are illegal)
//   - state_e           : arbiter FSM state encoding
//   - is_legal_op()     : true for opcodes 1..9
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND = 4'd1;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd2;
  localparam logic [OP_W-1:0] ALU_ADD = 4'd3;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLL = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRA = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRL = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLT = 4'd8;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op >= ALU_AND) && (op <= ALU_XOR);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a one-bit priority pointer.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   enable     : grants are only issued while high
//   req[1:0]   : request lines
//   gnt[1:0]   : one-hot (or zero) grant; a grant is treated as an accepted
//                handshake and moves the pointer to the other requester
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrating; winner sees reqX_ready, handshake latches operands
// ISSUE | latched operands drive the ALU; result captured at the edge
// RESP  | owner's resp_valid high until resp_ready; no new requests
//
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   req{0,1}_valid/ready/op/rs1/rs2: request channels (valid/ready)
//   resp{0,1}_valid/ready/rd/err   : response channels (valid/ready)
//   alu_rs1/alu_rs2/alu_op         : operands to the external ALU (0 outside ISSUE)
//   alu_rd                         : combinational result from the ALU
//   busy                           : high whenever the FSM is not IDLE
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int OP_W = alu_pkg::OP_W
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,

  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_rd,
  output logic            resp0_err,

  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_rd,
  output logic            resp1_err,

  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [OP_W-1:0] alu_op,
  input  logic [XLEN-1:0] alu_rd,

  output logic            busy
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            owner_q, owner_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            err_q, err_d;

  logic [1:0]      gnt;
  logic            op_legal;
  logic            in_resp;

  // Gating with reset keeps req_ready low while reset is asserted even if
  // a requester is already holding valid.
  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable ((state_q == ST_IDLE) && !reset),
    .req    ({req1_valid, req0_valid}),
    .gnt    (gnt)
  );

  assign op_legal = is_legal_op(op_q);
  assign in_resp  = (state_q == ST_RESP);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    err_d   = err_q;
    alu_rs1 = '0;
    alu_rs2 = '0;
    alu_op  = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = gnt[1];
          op_d    = gnt[1] ? req1_op  : req0_op;
          rs1_d   = gnt[1] ? req1_rs1 : req0_rs1;
          rs2_d   = gnt[1] ? req1_rs2 : req0_rs2;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_rs1 = rs1_q;
        alu_rs2 = rs2_q;
        // Illegal opcodes never reach the ALU; the result is forced to 0.
        alu_op  = op_legal ? op_q : '0;
        rd_d    = op_legal ? alu_rd : '0;
        err_d   = !op_legal;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if ((owner_q == 1'b0 && resp0_ready) || (owner_q == 1'b1 && resp1_ready)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];

  assign resp0_valid = in_resp && (owner_q == 1'b0);
  assign resp1_valid = in_resp && (owner_q == 1'b1);
  assign resp0_rd    = resp0_valid ? rd_q : '0;
  assign resp1_rd    = resp1_valid ? rd_q : '0;
  assign resp0_err   = resp0_valid && err_q;
  assign resp1_err   = resp1_valid && err_q;

  assign busy        = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      owner_q <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid [2];
  logic [3:0]  req_op    [2];
  logic [31:0] req_rs1   [2];
  logic [31:0] req_rs2   [2];
  logic        resp_ready[2];

  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [31:0] resp0_rd, resp1_rd;
  logic [31:0] alu_rs1, alu_rs2, alu_rd;
  logic [3:0]  alu_op;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int ptr = 0;   // model of which requester wins a tie

  alu_share_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req_valid[0]),
    .req0_ready  (req0_ready),
    .req0_op     (req_op[0]),
    .req0_rs1    (req_rs1[0]),
    .req0_rs2    (req_rs2[0]),
    .req1_valid  (req_valid[1]),
    .req1_ready  (req1_ready),
    .req1_op     (req_op[1]),
    .req1_rs1    (req_rs1[1]),
    .req1_rs2    (req_rs2[1]),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp_ready[0]),
    .resp0_rd    (resp0_rd),
    .resp0_err   (resp0_err),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp_ready[1]),
    .resp1_rd    (resp1_rd),
    .resp1_err   (resp1_err),
    .alu_rs1     (alu_rs1),
    .alu_rs2     (alu_rs2),
    .alu_op      (alu_op),
    .alu_rd      (alu_rd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each opcode; opcode 0 returns a marker value so a
  // leak of the raw ALU output on an illegal request would be visible.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd1:    return a & b;
      4'd2:    return a | b;
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a << b[4:0];
      4'd6:    return $signed(a) >>> b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return a ^ b;
      default: return 32'hBAD0_C0DE;
    endcase
  endfunction

  always_comb alu_rd = ref_alu(alu_op, alu_rs1, alu_rs2);

  function automatic logic rdy(input int id);
    return (id == 1) ? req1_ready : req0_ready;
  endfunction
  function automatic logic rvalid(input int id);
    return (id == 1) ? resp1_valid : resp0_valid;
  endfunction
  function automatic logic [31:0] rrd(input int id);
    return (id == 1) ? resp1_rd : resp0_rd;
  endfunction
  function automatic logic rerr(input int id);
    return (id == 1) ? resp1_err : resp0_err;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req0_ready"}, 32'(req0_ready), 0);
    check({tag, "_req1_ready"}, 32'(req1_ready), 0);
    check({tag, "_resp0_valid"}, 32'(resp0_valid), 0);
    check({tag, "_resp1_valid"}, 32'(resp1_valid), 0);
    check({tag, "_resp0_rd"}, resp0_rd, 0);
    check({tag, "_resp1_rd"}, resp1_rd, 0);
    check({tag, "_alu_op"}, 32'(alu_op), 0);
    check({tag, "_alu_rs1"}, alu_rs1, 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_resp(input int id, input logic [31:0] exp_rd, input logic exp_err);
    check("resp_valid_owner", 32'(rvalid(id)), 1);
    check("resp_rd_owner", rrd(id), exp_rd);
    check("resp_err_owner", 32'(rerr(id)), 32'(exp_err));
    check("resp_valid_other", 32'(rvalid(1 - id)), 0);
    check("resp_rd_other", rrd(1 - id), 0);
    check("resp_ready0", 32'(req0_ready), 0);
    check("resp_ready1", 32'(req1_ready), 0);
    check("resp_alu_op", 32'(alu_op), 0);
    check("resp_busy", 32'(busy), 1);
  endtask

  // Called away from a rising edge, with the DUT idle. Requester id must be
  // the expected winner for this cycle.
  task automatic serve(input int id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int bp);
    logic        legal;
    logic [31:0] exp_rd;
    legal  = (op >= 4'd1) && (op <= 4'd9);
    exp_rd = legal ? ref_alu(op, a, b) : 32'd0;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_rs1[id]   = a;
    req_rs2[id]   = b;
    #1;
    check("grant_winner", 32'(rdy(id)), 1);
    check("grant_loser", 32'(rdy(1 - id)), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_alu_op", 32'(alu_op), 0);
    @(posedge clk);
    #1;
    ptr = 1 - id;
    req_valid[id] = 1'b0;
    req_op[id]    = 4'($urandom);
    req_rs1[id]   = $urandom;
    req_rs2[id]   = $urandom;
    @(negedge clk);
    check("issue_alu_op", 32'(alu_op), legal ? 32'(op) : 0);
    check("issue_alu_rs1", alu_rs1, a);
    check("issue_alu_rs2", alu_rs2, b);
    check("issue_busy", 32'(busy), 1);
    check("issue_ready0", 32'(req0_ready), 0);
    check("issue_ready1", 32'(req1_ready), 0);
    check("issue_resp_valid", 32'(resp0_valid | resp1_valid), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_resp(id, exp_rd, !legal);
      @(posedge clk);
      #1;
    end
    resp_ready[id] = 1'b1;
    @(negedge clk);
    check_resp(id, exp_rd, !legal);
    @(posedge clk);
    #1;
    resp_ready[id] = 1'b0;
    @(negedge clk);
    check("after_resp_busy", 32'(busy), 0);
    check("after_resp_valid", 32'(rvalid(id)), 0);
  endtask

  // Both requesters raise valid in the same cycle; the model pointer picks
  // who goes first, the other is served straight afterwards.
  task automatic pair(input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                      input int bp);
    int w;
    int l;
    logic [3:0]  ops[2];
    logic [31:0] as[2];
    logic [31:0] bs[2];
    ops[0] = op0; as[0] = a0; bs[0] = b0;
    ops[1] = op1; as[1] = a1; bs[1] = b1;
    w = ptr;
    l = 1 - w;
    req_valid[l] = 1'b1;
    req_op[l]    = ops[l];
    req_rs1[l]   = as[l];
    req_rs2[l]   = bs[l];
    serve(w, ops[w], as[w], bs[w], bp);
    serve(l, ops[l], as[l], bs[l], bp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b1;
      req_op[i]     = 4'd3;
      req_rs1[i]    = 32'd1;
      req_rs2[i]    = 32'd1;
      resp_ready[i] = 1'b0;
    end
    #3;
    check_all_zero("in_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    check_all_zero("after_reset");
    @(negedge clk);

    serve(0, 4'd3, 32'd5, 32'd7, 0);
    pair(4'd4, 32'd3, 32'd5, 4'd4, 32'd3, 32'd5, 0);
    pair(4'd4, 32'd3, 32'd5, 4'd4, 32'd3, 32'd5, 1);
    serve(1, 4'd2, 32'h1234_0000, 32'h0000_5678, 5);
    serve(1, 4'd12, 32'hFFFF_FFFF, 32'h1, 1);
    serve(0, 4'd8, 32'd2, 32'd9, 0);
    serve(1, 4'd9, 32'hFF00_FF00, 32'h0F0F_0F0F, 0);
    serve(0, 4'd6, 32'h8000_0010, 32'd4, 0);
    serve(0, 4'd0, 32'h5, 32'h5, 0);

    // Asynchronous reset while a request is in ISSUE.
    serve_abort();

    pair(4'd1, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 4'd7, 32'h8000_0000, 32'd31, 0);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        pair(4'($urandom_range(0, 15)), $urandom, $urandom,
             4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2));
      end else begin
        serve($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom,
              $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic serve_abort();
    req_valid[0] = 1'b1;
    req_op[0]    = 4'd3;
    req_rs1[0]   = 32'd10;
    req_rs2[0]   = 32'd20;
    #1;
    check("abort_grant", 32'(req0_ready), 1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    req_op[1]    = 4'd3;
    #1;
    check("abort_issue_alu_op", 32'(alu_op), 3);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    req_valid[1] = 1'b0;
    ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_resp0", 32'(resp0_valid), 0);
      check("post_reset_busy", 32'(busy), 0);
    end
  endtask

endmodule
